// File: rtl/sn74xx258_if.sv
// Bus bundle for the sn74xx258 quad 2-to-1 selector: data words, select, enable and 3-state output.
// `out` is a net so that several selector instances can share it and take turns driving it.
interface sn74xx258_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             oe;
    wire  [WIDTH-1:0] out;

    modport master (output a, b, sel, oe, input out);
    modport slave  (input a, b, sel, oe, output out);
endinterface

// File: rtl/sn74xx258.sv
// Quad 2-to-1 data selector with optional inversion and 3-state outputs (74x258 / 74x257 function).
// Define SN74XX258_OUTREG_EN to register the selected word (one cycle latency); oe stays combinational.
module sn74xx258 #(
    parameter int WIDTH  = 4,
    parameter bit INVERT = 1'b1
) (
    input logic        clk,
    input logic        rst,
    sn74xx258_if.slave bus
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] y;

    // A ternary on an unknown select merges the two words bitwise, which is the
    // 74x258 behaviour: bits where a and b agree still resolve.
    assign d = bus.sel ? bus.b : bus.a;
    assign y = INVERT ? ~d : d;

`ifdef SN74XX258_OUTREG_EN
    logic [WIDTH-1:0] q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= y;
    end

    assign bus.out = bus.oe ? {WIDTH{1'bz}} : q;
`else
    // Clock and reset exist only for port compatibility with the registered build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign bus.out = bus.oe ? {WIDTH{1'bz}} : y;
`endif
endmodule

// File: tb/tb_sn74xx258.sv
// Self-checking bench for sn74xx258: inverting and true-output instances share their buses with a bench driver.
// Covers both the combinational build and the SN74XX258_OUTREG_EN registered build.
module tb_sn74xx258;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    sn74xx258_if #(.WIDTH(W)) bus_i ();
    sn74xx258_if #(.WIDTH(W)) bus_t ();

    // Second bus talker: drives only while the DUT is meant to be off the bus.
    logic         drv_en = 1'b0;
    logic [W-1:0] drv_i  = '0;
    logic [W-1:0] drv_t  = '0;
    assign bus_i.out = drv_en ? drv_i : {W{1'bz}};
    assign bus_t.out = drv_en ? drv_t : {W{1'bz}};

    sn74xx258 #(.WIDTH(W), .INVERT(1'b1)) u_inv  (.clk(clk), .rst(rst), .bus(bus_i));
    sn74xx258 #(.WIDTH(W), .INVERT(1'b0)) u_true (.clk(clk), .rst(rst), .bus(bus_t));

    always #5 clk = ~clk;

    // Reference: pick the word, then take the complement arithmetically when inverting.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sel, input bit inv);
        int word;
        word = sel ? int'(b) : int'(a);
        if (inv) word = (2 ** W - 1) - word;
        return W'(word);
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel, input logic oe);
        bus_i.a = a; bus_i.b = b; bus_i.sel = sel; bus_i.oe = oe;
        bus_t.a = a; bus_t.b = b; bus_t.sel = sel; bus_t.oe = oe;
        // The bench talks on the bus only while the selectors are disabled, using a value the DUT would not drive.
        drv_i  = ~model(a, b, sel, 1'b1);
        drv_t  = ~model(a, b, sel, 1'b0);
        drv_en = oe;
    endtask

    // Let new inputs reach the output: one edge in the registered build, a settle delay otherwise.
    task automatic step();
`ifdef SN74XX258_OUTREG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: out=%b expected=%b", name, got, want);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(4'b1010, 4'b1111, 1'b0, 1'b0);
        @(posedge clk); #1;
`ifdef SN74XX258_OUTREG_EN
        cmp("reset_clears", bus_i.out, 4'b0000);
        rst = 1'b0;
        step();
        cmp("reset_release_sel0", bus_i.out, 4'b0101);
`else
        cmp("reset_ignored", bus_i.out, 4'b0101);
        rst = 1'b0;
`endif
    endtask

    task automatic test_select();
        drive(4'b1010, 4'b1111, 1'b0, 1'b0); step();
        cmp("sel0_inv", bus_i.out, 4'b0101);
        drive(4'b1010, 4'b1111, 1'b1, 1'b0); step();
        cmp("sel1_inv", bus_i.out, 4'b0000);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0); step();
        cmp("zero_sel0", bus_i.out, 4'b1111);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0); step();
        cmp("zero_sel1", bus_i.out, 4'b1111);
    endtask

    task automatic test_oe();
        drive(4'b1010, 4'b1111, 1'b0, 1'b1); #1;
        cmp("oe_off_sel0", bus_i.out, drv_i);
        drive(4'b1010, 4'b1111, 1'b1, 1'b1); #1;
        cmp("oe_off_sel1", bus_i.out, drv_i);
        cmp("oe_off_true", bus_t.out, drv_t);
`ifdef SN74XX258_OUTREG_EN
        // Register keeps loading while disabled; the new word must appear as soon as oe falls.
        repeat (2) @(posedge clk);
        #1;
`endif
        drive(4'b1010, 4'b1111, 1'b1, 1'b0); #1;
        cmp("oe_on_immediate", bus_i.out, 4'b0000);
        drive(4'b1010, 4'b1111, 1'b0, 1'b0); step();
        cmp("oe_on_sel0", bus_i.out, 4'b0101);
    endtask

    task automatic test_walking();
        logic [W-1:0] a;
        for (int i = 0; i < W; i++) begin
            a = W'(1) << i;
            drive(a, 4'b0000, 1'b0, 1'b0); step();
            cmp($sformatf("walk_%0d", i), bus_i.out, model(a, 4'b0000, 1'b0, 1'b1));
        end
    endtask

    task automatic test_true_outputs();
        drive(4'b1010, 4'b1111, 1'b0, 1'b0); step();
        cmp("true_sel0", bus_t.out, 4'b1010);
        drive(4'b1010, 4'b1111, 1'b1, 1'b0); step();
        cmp("true_sel1", bus_t.out, 4'b1111);
    endtask

`ifdef SN74XX258_OUTREG_EN
    task automatic test_latency();
        drive(4'b1010, 4'b1111, 1'b0, 1'b0); step();
        @(negedge clk);
        drive(4'b1010, 4'b1111, 1'b1, 1'b0); #1;
        cmp("latency_hold", bus_i.out, 4'b0101);
        @(posedge clk); #1;
        cmp("latency_load", bus_i.out, 4'b0000);
        @(negedge clk);
        drive(4'b1010, 4'b1111, 1'b1, 1'b1); #1;
        cmp("latency_oe_off", bus_i.out, drv_i);
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] a, b, want_i, want_t;
        logic         sel, oe, r;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a   = W'($urandom);
            b   = W'($urandom);
            sel = 1'($urandom);
            oe  = ($urandom_range(0, 3) == 0);
`ifdef SN74XX258_OUTREG_EN
            r = ($urandom_range(0, 7) == 0);
`else
            r = 1'($urandom);
`endif
            rst = r;
            drive(a, b, sel, oe);
            @(posedge clk); #1;
            want_i = model(a, b, sel, 1'b1);
            want_t = model(a, b, sel, 1'b0);
`ifdef SN74XX258_OUTREG_EN
            if (r) begin
                want_i = '0;
                want_t = '0;
            end
`endif
            if (oe) begin
                want_i = drv_i;
                want_t = drv_t;
            end
            cmp($sformatf("rand_inv_%0d", n), bus_i.out, want_i);
            cmp($sformatf("rand_true_%0d", n), bus_t.out, want_t);
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        test_reset();
        test_select();
        test_oe();
        test_walking();
        test_true_outputs();
`ifdef SN74XX258_OUTREG_EN
        test_latency();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
